// File: rtl/sram_boot_pkg.sv
// Shared state type, SRAM strobe idle levels and sizing helper for the SRAM boot loader.
package sram_boot_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } ldr_state_t;

    // SRAM strobes are active-low: these are the "do nothing" levels.
    localparam logic       CEN_OFF  = 1'b1;
    localparam logic       GWEN_OFF = 1'b1;
    localparam logic [7:0] WEN_OFF  = 8'hFF;
    localparam logic [7:0] WEN_ALL  = 8'h00;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_port_mux.sv
// One channel's SRAM port select: CPU pass-through, loader write, or loader idle strobes.
module sram_port_mux
    import sram_boot_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int ADDR_W = 9
) (
    input  logic                         i_use_cpu,
    input  logic                         i_ld_write,
    input  logic [ADDR_W-1:0]            i_ld_addr,
    input  logic [LANES-1:0][7:0]        i_ld_data,
    input  logic [LANES-1:0]             i_cpu_cen,
    input  logic [LANES-1:0]             i_cpu_gwen,
    input  logic [LANES-1:0][7:0]        i_cpu_wen,
    input  logic [LANES-1:0][ADDR_W-1:0] i_cpu_a,
    input  logic [LANES-1:0][7:0]        i_cpu_d,
    output logic [LANES-1:0]             o_mem_cen,
    output logic [LANES-1:0]             o_mem_gwen,
    output logic [LANES-1:0][7:0]        o_mem_wen,
    output logic [LANES-1:0][ADDR_W-1:0] o_mem_a,
    output logic [LANES-1:0][7:0]        o_mem_d
);

    // NOTE: every branch drives every output, so no latch can be inferred.
    always_comb begin
        if (i_use_cpu) begin
            o_mem_cen  = i_cpu_cen;
            o_mem_gwen = i_cpu_gwen;
            o_mem_wen  = i_cpu_wen;
            o_mem_a    = i_cpu_a;
            o_mem_d    = i_cpu_d;
        end else if (i_ld_write) begin
            o_mem_cen  = '0;
            o_mem_gwen = '0;
            o_mem_wen  = {LANES{WEN_ALL}};
            o_mem_a    = {LANES{i_ld_addr}};
            o_mem_d    = i_ld_data;
        end else begin
            o_mem_cen  = {LANES{CEN_OFF}};
            o_mem_gwen = {LANES{GWEN_OFF}};
            o_mem_wen  = {LANES{WEN_OFF}};
            o_mem_a    = '0;
            o_mem_d    = '0;
        end
    end

endmodule

// File: rtl/sram_boot_loader.sv
// Loads instruction/data SRAMs from a byte stream (or zero-fills them) while holding the core in reset.
module sram_boot_loader
    import sram_boot_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int ADDR_W   = 9,
    parameter int DEPTH    = 512,
    parameter int CHANNELS = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic                                       zero_fill,
    input  logic                                       s_valid,
    input  logic [7:0]                                 s_data,
    output logic                                       s_ready,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       core_hold,
    input  logic [CHANNELS-1:0][LANES-1:0]             cpu_CEN,
    input  logic [CHANNELS-1:0][LANES-1:0]             cpu_GWEN,
    input  logic [CHANNELS-1:0][LANES-1:0][7:0]        cpu_WEN,
    input  logic [CHANNELS-1:0][LANES-1:0][ADDR_W-1:0] cpu_A,
    input  logic [CHANNELS-1:0][LANES-1:0][7:0]        cpu_D,
    output logic [CHANNELS-1:0][LANES-1:0]             mem_CEN,
    output logic [CHANNELS-1:0][LANES-1:0]             mem_GWEN,
    output logic [CHANNELS-1:0][LANES-1:0][7:0]        mem_WEN,
    output logic [CHANNELS-1:0][LANES-1:0][ADDR_W-1:0] mem_A,
    output logic [CHANNELS-1:0][LANES-1:0][7:0]        mem_D
);

    localparam int LANE_W = cnt_width(LANES);
    localparam int CHAN_W = cnt_width(CHANNELS);

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(CHANNELS - 1);

    ldr_state_t             r_state;
    logic [CHAN_W-1:0]      r_chan;
    logic [ADDR_W-1:0]      r_word;
    logic [LANE_W-1:0]      r_lane;
    logic [LANES-1:0][7:0]  r_buf;
    logic                   r_zero;
    logic                   r_s_ready;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_core_hold;

    logic                   w_accept;
    logic                   w_last_word;
    logic                   w_last_chan;
    logic                   w_use_cpu;
    logic [LANES-1:0][7:0]  w_ld_data;

    assign w_accept    = s_valid && r_s_ready;
    assign w_last_word = (r_word == LAST_WORD);
    assign w_last_chan = (r_chan == LAST_CHAN);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_chan      <= '0;
            r_word      <= '0;
            r_lane      <= '0;
            r_buf       <= '0;
            r_zero      <= 1'b0;
            r_s_ready   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_core_hold <= 1'b1;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_chan      <= '0;
                        r_word      <= '0;
                        r_lane      <= '0;
                        r_buf       <= '0;
                        r_zero      <= zero_fill;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_core_hold <= 1'b1;
                        if (zero_fill) begin
                            r_state   <= WRITE;
                            r_s_ready <= 1'b0;
                        end else begin
                            r_state   <= COLLECT;
                            r_s_ready <= 1'b1;
                        end
                    end
                end

                COLLECT: begin
                    if (w_accept) begin
                        r_buf[r_lane] <= s_data;
                        if (r_lane == LAST_LANE) begin
                            r_lane    <= '0;
                            r_state   <= WRITE;
                            r_s_ready <= 1'b0;
                        end else begin
                            r_lane <= r_lane + LANE_W'(1);
                        end
                    end
                end

                WRITE: begin
                    if (w_last_word) begin
                        r_word <= '0;
                        r_chan <= w_last_chan ? '0 : r_chan + CHAN_W'(1);
                    end else begin
                        r_word <= r_word + ADDR_W'(1);
                    end

                    if (w_last_word && w_last_chan) begin
                        r_state     <= DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_core_hold <= 1'b0;
                    end else if (!r_zero) begin
                        r_state   <= COLLECT;
                        r_s_ready <= 1'b1;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_ready   = r_s_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign core_hold = r_core_hold;

    // Select comes from the registered state only, so a start pulse never glitches the SRAM ports.
    assign w_use_cpu = (r_state == IDLE) || (r_state == DONE);
    assign w_ld_data = r_zero ? '0 : r_buf;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic w_ld_write;
        assign w_ld_write = (r_state == WRITE) && (r_chan == CHAN_W'(c));

        sram_port_mux #(
            .LANES  (LANES),
            .ADDR_W (ADDR_W)
        ) u_mux (
            .i_use_cpu  (w_use_cpu),
            .i_ld_write (w_ld_write),
            .i_ld_addr  (r_word),
            .i_ld_data  (w_ld_data),
            .i_cpu_cen  (cpu_CEN[c]),
            .i_cpu_gwen (cpu_GWEN[c]),
            .i_cpu_wen  (cpu_WEN[c]),
            .i_cpu_a    (cpu_A[c]),
            .i_cpu_d    (cpu_D[c]),
            .o_mem_cen  (mem_CEN[c]),
            .o_mem_gwen (mem_GWEN[c]),
            .o_mem_wen  (mem_WEN[c]),
            .o_mem_a    (mem_A[c]),
            .o_mem_d    (mem_D[c])
        );
    end

endmodule

// File: tb/tb_sram_boot_loader.sv
// Scoreboard bench: expected SRAM write cycles are queued at stimulus time and popped by a monitor.
module tb_sram_boot_loader;

    localparam int LN = 4;
    localparam int AW = 9;
    localparam int CH = 2;
    localparam int DA = 2;
    localparam int DB = 4;

    typedef logic [CH-1:0][LN-1:0]         bit_t;
    typedef logic [CH-1:0][LN-1:0][7:0]    byte_t;
    typedef logic [CH-1:0][LN-1:0][AW-1:0] addr_t;
    typedef logic [LN-1:0][7:0]            word_t;

    typedef struct packed {
        bit_t  cen;
        bit_t  gwen;
        byte_t wen;
        addr_t a;
        byte_t d;
    } port_t;

    localparam int PW = $bits(port_t);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       zero_fill = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    bit_t       cpu_CEN, cpu_GWEN;
    byte_t      cpu_WEN, cpu_D;
    addr_t      cpu_A;

    logic  s_ready_a, busy_a, done_a, core_hold_a;
    logic  s_ready_b, busy_b, done_b, core_hold_b;
    bit_t  mem_CEN_a, mem_GWEN_a, mem_CEN_b, mem_GWEN_b;
    byte_t mem_WEN_a, mem_D_a, mem_WEN_b, mem_D_b;
    addr_t mem_A_a, mem_A_b;

    port_t port_a, port_b, cpu_port;
    assign port_a   = {mem_CEN_a, mem_GWEN_a, mem_WEN_a, mem_A_a, mem_D_a};
    assign port_b   = {mem_CEN_b, mem_GWEN_b, mem_WEN_b, mem_A_b, mem_D_b};
    assign cpu_port = {cpu_CEN, cpu_GWEN, cpu_WEN, cpu_A, cpu_D};

    sram_boot_loader #(.LANES(LN), .ADDR_W(AW), .DEPTH(DA), .CHANNELS(CH)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .zero_fill(zero_fill),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_a),
        .busy(busy_a), .done(done_a), .core_hold(core_hold_a),
        .cpu_CEN(cpu_CEN), .cpu_GWEN(cpu_GWEN), .cpu_WEN(cpu_WEN), .cpu_A(cpu_A), .cpu_D(cpu_D),
        .mem_CEN(mem_CEN_a), .mem_GWEN(mem_GWEN_a), .mem_WEN(mem_WEN_a), .mem_A(mem_A_a), .mem_D(mem_D_a)
    );

    sram_boot_loader #(.LANES(LN), .ADDR_W(AW), .DEPTH(DB), .CHANNELS(CH)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .zero_fill(zero_fill),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_b),
        .busy(busy_b), .done(done_b), .core_hold(core_hold_b),
        .cpu_CEN(cpu_CEN), .cpu_GWEN(cpu_GWEN), .cpu_WEN(cpu_WEN), .cpu_A(cpu_A), .cpu_D(cpu_D),
        .mem_CEN(mem_CEN_b), .mem_GWEN(mem_GWEN_b), .mem_WEN(mem_WEN_b), .mem_A(mem_A_b), .mem_D(mem_D_b)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic       mon_en = 1'b0;
    port_t      qa[$];
    port_t      qb[$];
    int         wr_cyc_b[$];
    logic [7:0] stream_q[$];
    logic [7:0] sram [2][CH][1 << AW][LN];

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic port_t idle_port();
        port_t p;
        p.cen  = '1;
        p.gwen = '1;
        p.wen  = '1;
        p.a    = '0;
        p.d    = '0;
        return p;
    endfunction

    function automatic port_t write_port(input int ch, input int addr, input word_t data);
        port_t p = idle_port();
        for (int l = 0; l < LN; l++) begin
            p.cen[ch][l]  = 1'b0;
            p.gwen[ch][l] = 1'b0;
            p.wen[ch][l]  = 8'h00;
            p.a[ch][l]    = AW'(addr);
            p.d[ch][l]    = data[l];
        end
        return p;
    endfunction

    // Behavioural SRAM contents and write scoreboard for one instance.
    task automatic monitor_inst(input int inst, input port_t p, input logic rdy, input logic bsy);
        port_t e;
        logic  wr;
        wr = !(&p.cen);
        if (wr) begin
            for (int c = 0; c < CH; c++)
                for (int l = 0; l < LN; l++)
                    if (!p.cen[c][l] && !p.gwen[c][l]) sram[inst][c][p.a[c][l]][l] = p.d[c][l];
            if (inst == 1) wr_cyc_b.push_back(cyc);
            if ((inst == 0 && qa.size() == 0) || (inst == 1 && qb.size() == 0)) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write inst=%0d act=%h exp=none", inst, p);
            end else begin
                if (inst == 0) e = qa.pop_front();
                else           e = qb.pop_front();
                check("write_cycle", p, e);
            end
        end else if (bsy) begin
            check("idle_strobes", p, idle_port());
        end
        if (rdy) check("s_ready_only_collect", {wr, bsy}, 2'b01);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!rst && mon_en) begin
            monitor_inst(0, port_a, s_ready_a, busy_a);
            monitor_inst(1, port_b, s_ready_b, busy_b);
        end
    end

    task automatic cpu_idle();
        cpu_CEN  = '1;
        cpu_GWEN = '1;
        cpu_WEN  = '1;
        cpu_A    = '0;
        cpu_D    = '0;
    endtask

    task automatic cpu_random();
        cpu_CEN  = bit_t'($urandom);
        cpu_GWEN = bit_t'($urandom);
        cpu_WEN  = byte_t'({$urandom, $urandom});
        cpu_A    = addr_t'({$urandom, $urandom, $urandom});
        cpu_D    = byte_t'({$urandom, $urandom});
    endtask

    task automatic make_stream(input int n, input logic seq);
        stream_q.delete();
        for (int i = 0; i < n; i++) stream_q.push_back(seq ? 8'(i) : 8'($urandom));
    endtask

    task automatic push_expected(input int inst, input int depth, input logic zf);
        word_t data;
        for (int c = 0; c < CH; c++)
            for (int w = 0; w < depth; w++) begin
                for (int l = 0; l < LN; l++) data[l] = zf ? 8'h00 : stream_q[(c * depth + w) * LN + l];
                if (inst == 0) qa.push_back(write_port(c, w, data));
                else           qb.push_back(write_port(c, w, data));
            end
    endtask

    task automatic pulse_start(input int inst, input logic zf);
        @(negedge clk);
        zero_fill = zf;
        if (inst == 0) start_a = 1'b1;
        else           start_b = 1'b1;
        @(negedge clk);
        start_a   = 1'b0;
        start_b   = 1'b0;
        zero_fill = 1'b0;
    endtask

    // vmode: 0 always valid, 1 toggle, 2 random, 3 always valid plus a stray start mid-word.
    task automatic send_bytes(input int n, input int vmode);
        int   idx = 0;
        int   budget = 0;
        logic tog = 1'b1;
        logic pulsed = 1'b0;
        while (idx < n && budget < 2000) begin
            @(negedge clk);
            start_a   = 1'b0;
            zero_fill = 1'b0;
            case (vmode)
                1:       begin s_valid = tog; tog = !tog; end
                2:       s_valid = 1'($urandom_range(0, 1));
                default: s_valid = 1'b1;
            endcase
            if (vmode == 3 && idx == 2 && !pulsed) begin
                start_a   = 1'b1;
                zero_fill = 1'b1;
                pulsed    = 1'b1;
            end
            s_data = stream_q[idx];
            if (s_valid && s_ready_a) idx++;
            budget++;
        end
        @(negedge clk);
        s_valid   = 1'b0;
        start_a   = 1'b0;
        zero_fill = 1'b0;
        check("stream_accepted", idx, n);
    endtask

    task automatic wait_done(input int inst, input string name);
        int n = 0;
        while (n < 500 && !(inst == 0 ? done_a : done_b)) begin
            if (inst == 1) check("zf_s_ready_low", s_ready_b, 1'b0);
            @(negedge clk);
            n++;
        end
        if (inst == 0) begin
            check({name, "_status"}, {s_ready_a, busy_a, done_a, core_hold_a}, 4'b0010);
            check({name, "_drained"}, qa.size(), 0);
        end else begin
            check({name, "_status"}, {s_ready_b, busy_b, done_b, core_hold_b}, 4'b0010);
            check({name, "_drained"}, qb.size(), 0);
        end
    endtask

    task automatic check_sram(input int inst, input int depth, input logic zf, input string name);
        word_t got, exp;
        for (int c = 0; c < CH; c++)
            for (int w = 0; w < depth; w++) begin
                for (int l = 0; l < LN; l++) begin
                    got[l] = sram[inst][c][w][l];
                    exp[l] = zf ? 8'h00 : stream_q[(c * depth + w) * LN + l];
                end
                check(name, got, exp);
            end
    endtask

    task automatic load_a(input logic seq, input int vmode, input string name);
        make_stream(CH * DA * LN, seq);
        push_expected(0, DA, 1'b0);
        pulse_start(0, 1'b0);
        check({name, "_collect"}, {s_ready_a, busy_a, done_a, core_hold_a}, 4'b1101);
        send_bytes(CH * DA * LN, vmode);
        wait_done(0, name);
        check_sram(0, DA, 1'b0, {name, "_sram"});
    endtask

    initial begin
        word_t first;
        int    span;

        cpu_random();
        #12;
        check("rst_status_a", {s_ready_a, busy_a, done_a, core_hold_a}, 4'b0001);
        check("rst_status_b", {s_ready_b, busy_b, done_b, core_hold_b}, 4'b0001);
        check("rst_passthru", port_a, cpu_port);
        cpu_idle();
        #2 rst = 1'b0;
        mon_en = 1'b1;

        load_a(1'b1, 0, "seq_load");

        // CPU owns the ports combinationally once loading is done.
        #2 mon_en = 1'b0;
        cpu_random();
        cpu_A[1][2]   = 9'h1FF;
        cpu_CEN[1][2] = 1'b0;
        #1;
        check("done_A12", mem_A_a[1][2], 9'h1FF);
        check("done_CEN12", mem_CEN_a[1][2], 1'b0);
        check("done_passthru", port_a, cpu_port);
        cpu_idle();
        #1 mon_en = 1'b1;

        push_expected(0, DA, 1'b1);
        pulse_start(0, 1'b1);
        check("zf_a_write", {s_ready_a, busy_a, done_a, core_hold_a}, 4'b0101);
        wait_done(0, "zf_a");
        check_sram(0, DA, 1'b1, "zf_a_sram");

        load_a(1'b1, 1, "toggle_load");
        load_a(1'b0, 2, "rand_load");
        load_a(1'b0, 3, "stray_start");

        push_expected(1, DB, 1'b1);
        wr_cyc_b.delete();
        pulse_start(1, 1'b1);
        wait_done(1, "zf_b");
        check("zf_b_writes", wr_cyc_b.size(), CH * DB);
        span = (wr_cyc_b.size() > 0) ? wr_cyc_b[wr_cyc_b.size() - 1] - wr_cyc_b[0] : -1;
        check("zf_b_consecutive", span, CH * DB - 1);
        check_sram(1, DB, 1'b1, "zf_b_sram");

        // Reset partway through the second word abandons the load.
        make_stream(CH * DA * LN, 1'b0);
        for (int l = 0; l < LN; l++) first[l] = stream_q[l];
        qa.push_back(write_port(0, 0, first));
        pulse_start(0, 1'b0);
        send_bytes(5, 0);
        s_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("midrst_status", {s_ready_a, busy_a, done_a, core_hold_a}, 4'b0001);
        check("midrst_passthru", port_a, cpu_port);
        #1 rst = 1'b0;
        repeat (10) @(negedge clk);
        s_valid = 1'b0;
        check("midrst_status_after", {s_ready_a, busy_a, done_a, core_hold_a}, 4'b0001);
        check("midrst_drained", qa.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sram_boot_loader.md
SRAM_BOOT_LOADER -- requirements
Module: sram_boot_loader

Interface
REQ-001 SHALL have parameter LANES, default 4: byte lanes (SRAM macros) per channel.
REQ-002 SHALL have parameter ADDR_W, default 9: SRAM word address width.
REQ-003 SHALL have parameter DEPTH, default 512: words loaded per channel, 1..2**ADDR_W.
REQ-004 SHALL have parameter CHANNELS, default 2: memories loaded in order (0 = imem, 1 = dmem).
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: pulse that begins a load.
REQ-008 SHALL have port zero_fill, input, 1 bit: sampled with start; selects writing zeros with no stream input.
REQ-009 SHALL have ports s_valid (input, 1), s_data (input, 8) and s_ready (output, 1): byte stream with valid/ready handshake.
REQ-010 SHALL have ports busy (output, 1), done (output, 1) and core_hold (output, 1): loader status and core reset request.
REQ-011 SHALL have CPU-side inputs cpu_CEN and cpu_GWEN ([CHANNELS][LANES] x 1), cpu_WEN and cpu_D ([CHANNELS][LANES] x 8), and cpu_A ([CHANNELS][LANES] x ADDR_W).
REQ-012 SHALL have memory-side outputs mem_CEN, mem_GWEN, mem_WEN, mem_A and mem_D, with the same shapes as the CPU-side inputs.
REQ-013 SHALL treat CEN, GWEN and WEN as active-low on both sides.

Function
REQ-014 SHALL have the FSM states IDLE, COLLECT, WRITE and DONE.
REQ-015 SHALL go from IDLE or DONE to COLLECT when start=1 (to WRITE if zero_fill=1), with channel, word and lane counters cleared; start is ignored in COLLECT and WRITE.
REQ-016 SHALL assert s_ready only in COLLECT, and SHALL accept a byte when s_valid&&s_ready.
REQ-017 SHALL place accepted byte k of a word in lane k (little-endian) and, on the LANES-th accepted byte, SHALL move to WRITE.
REQ-018 SHALL, for exactly one cycle in WRITE, drive on the current channel, all lanes: mem_CEN=0, mem_GWEN=0, mem_WEN=8'h00, mem_A=word, mem_D=assembled byte (zeros in zero_fill mode).
REQ-019 SHALL drive the other channels in WRITE, and all channels in COLLECT, with CEN=1, GWEN=1, WEN=8'hFF, A=0 and D=0.
REQ-020 SHALL, after WRITE, increment the word counter; at word DEPTH-1 it wraps to 0 and the channel increments.
REQ-021 SHALL go to DONE after the write of word DEPTH-1 of channel CHANNELS-1; otherwise it returns to COLLECT (or stays in WRITE in zero_fill mode).
REQ-022 SHALL give a zero_fill load a duration of exactly CHANNELS*DEPTH cycles of WRITE.
REQ-023 SHALL set busy=1 in COLLECT and WRITE, done=1 only in DONE, and core_hold=1 in every state except DONE.
REQ-024 SHALL pass all cpu_* inputs to mem_* outputs combinationally in IDLE and DONE; the mux select is derived only from the registered state.
REQ-025 SHALL, when s_valid stays low, keep COLLECT holding its partial word indefinitely, with no timeout.

Reset
REQ-026 SHALL, on rst=1, immediately and asynchronously put the FSM in IDLE and clear all counters and the word buffer.
REQ-027 SHALL, on reset, set s_ready=0, busy=0, done=0, core_hold=1 and route mem_* from cpu_*.
REQ-028 SHALL let a reset during a load abandon it; writes already done stay in SRAM, and a new start is needed.

Structure
REQ-029 SHALL place the state enum (ldr_state_t) and the SRAM strobe idle constants (CEN_OFF, WEN_OFF) in package sram_boot_pkg.
REQ-030 SHALL use one sub-module, sram_port_mux, for the per-channel select between the CPU and the loader.

Verification
REQ-031 SHALL cover: LANES=4, DEPTH=2, CHANNELS=2, stream 00..0F -> four write cycles: ch0 A0 D{03,02,01,00}, ch0 A1, ch1 A0, ch1 A1 D{0F,0E,0D,0C}; done=1.
REQ-032 SHALL cover: s_valid toggled 1/0 every cycle -> identical SRAM contents, s_ready never high outside COLLECT.
REQ-033 SHALL cover: zero_fill=1, DEPTH=4, CHANNELS=2 -> 8 consecutive WRITE cycles of 8'h00, then DONE, with s_ready=0 throughout.
REQ-034 SHALL cover: rst pulse after 5 bytes -> same cycle IDLE, core_hold=1, busy=0, and no further mem_CEN=0 from the loader.
REQ-035 SHALL cover: start pulsed during COLLECT -> ignored, counters unchanged.
REQ-036 SHALL cover: in DONE, cpu_A[1][2]=9'h1FF, cpu_CEN[1][2]=0 -> mem_A[1][2]=9'h1FF and mem_CEN[1][2]=0 in the same cycle.
